// File: rtl/cpu_subsystem.sv
// cpu_subsystem: single-cycle ARMv4-subset core (AND/SUB/ADD/ORR/CMP, LDR/STR,
// B), its memory-map chipset and the load read-data mux.
// Optional feature macro: CPU_SHIFTER_EN adds a barrel shifter on the register
// Src2 operand (LSL/LSR/ASR/ROR by a 5-bit immediate amount).
module cpu_subsystem (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instr,
   input  logic [31:0] RAMData,
   input  logic [31:0] Msj,
   output logic [31:0] PC,
   output logic [31:0] WriteData,
   output logic [31:0] Addr,
   output logic        MemWrite,
   output logic        RAMEnable
);

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_e;

   // instruction fields
   logic [3:0]  cond;
   logic [1:0]  op;
   logic        i_bit;
   logic [3:0]  cmd;
   logic        s_bit;
   logic [3:0]  rn;
   logic [3:0]  rd;
   logic [3:0]  rm;

   // architectural state: R0-R14 plus NZCV (bit3=N .. bit0=V)
   logic [31:0] regs [0:14];
   logic [3:0]  nzcv;

   logic [31:0] pc_plus4;
   logic [31:0] pc_plus8;
   logic [31:0] rn_val;
   logic [31:0] rd_val;
   logic [31:0] rm_val;
   logic [31:0] imm_rot;
   logic [63:0] imm_dbl;
   logic [31:0] sh_out;
   logic        sh_carry;
   logic [31:0] dp_src2;
   logic [31:0] src_b;
   logic [31:0] b_eff;
   logic [32:0] sum;
   logic [31:0] alu_result;
   logic        add_c;
   logic        add_v;
   alu_op_e     alu_op;
   logic        dp_valid;
   logic        is_cmp;
   logic        logical;
   logic        cond_ok;
   logic        is_ldr;
   logic        is_str;
   logic        is_b;
   logic        reg_write;
   logic        flag_write;
   logic [3:0]  nzcv_next;
   logic        ram_sel;
   logic [31:0] read_data;
   logic [31:0] result_wb;
   logic [31:0] pc_next;

   assign cond  = Instr[31:28];
   assign op    = Instr[27:26];
   assign i_bit = Instr[25];
   assign cmd   = Instr[24:21];
   assign s_bit = Instr[20];
   assign rn    = Instr[19:16];
   assign rd    = Instr[15:12];
   assign rm    = Instr[3:0];

   assign pc_plus4 = PC + 32'd4;
   assign pc_plus8 = PC + 32'd8;

   // register read ports; R15 reads as the pipeline-visible PC+8
   always_comb begin
      rn_val = (rn == 4'd15) ? pc_plus8 : regs[rn];
      rd_val = (rd == 4'd15) ? pc_plus8 : regs[rd];
      rm_val = (rm == 4'd15) ? pc_plus8 : regs[rm];
   end

   // condition evaluation against current NZCV; code 1111 never executes
   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'h0: cond_ok = nzcv[2];
         4'h1: cond_ok = ~nzcv[2];
         4'h2: cond_ok = nzcv[1];
         4'h3: cond_ok = ~nzcv[1];
         4'h4: cond_ok = nzcv[3];
         4'h5: cond_ok = ~nzcv[3];
         4'h6: cond_ok = nzcv[0];
         4'h7: cond_ok = ~nzcv[0];
         4'h8: cond_ok = nzcv[1] & ~nzcv[2];
         4'h9: cond_ok = ~nzcv[1] | nzcv[2];
         4'hA: cond_ok = (nzcv[3] == nzcv[0]);
         4'hB: cond_ok = (nzcv[3] != nzcv[0]);
         4'hC: cond_ok = ~nzcv[2] & (nzcv[3] == nzcv[0]);
         4'hD: cond_ok = nzcv[2] | (nzcv[3] != nzcv[0]);
         4'hE: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // immediate Src2: imm8 rotated right by 2*rot4 (rotate via doubled word)
   always_comb begin
      imm_dbl = {24'd0, Instr[7:0], 24'd0, Instr[7:0]} >> {Instr[11:8], 1'b0};
      imm_rot = imm_dbl[31:0];
   end

`ifdef CPU_SHIFTER_EN
   logic [1:0]  sh;
   logic [4:0]  shamt;
   logic [32:0] sh_tmp;
   logic [63:0] ror_dbl;

   assign sh    = Instr[6:5];
   assign shamt = Instr[11:7];

   // barrel shifter; amount 0 encodes LSL#0, LSR#32, ASR#32 and RRX
   always_comb begin
      sh_out   = rm_val;
      sh_carry = nzcv[1];
      sh_tmp   = '0;
      ror_dbl  = '0;
      case (sh)
         2'b00: begin
            if (shamt != 5'd0) begin
               sh_tmp   = {1'b0, rm_val} << shamt;
               sh_out   = sh_tmp[31:0];
               sh_carry = sh_tmp[32];
            end
         end
         2'b01: begin
            if (shamt == 5'd0) begin
               sh_out   = '0;
               sh_carry = rm_val[31];
            end else begin
               sh_tmp   = {rm_val, 1'b0} >> shamt;
               sh_out   = sh_tmp[32:1];
               sh_carry = sh_tmp[0];
            end
         end
         2'b10: begin
            if (shamt == 5'd0) begin
               sh_out   = {32{rm_val[31]}};
               sh_carry = rm_val[31];
            end else begin
               sh_tmp   = $signed({rm_val, 1'b0}) >>> shamt;
               sh_out   = sh_tmp[32:1];
               sh_carry = sh_tmp[0];
            end
         end
         default: begin
            if (shamt == 5'd0) begin
               sh_out   = {nzcv[1], rm_val[31:1]};
               sh_carry = rm_val[0];
            end else begin
               ror_dbl  = {rm_val, rm_val} >> shamt;
               sh_out   = ror_dbl[31:0];
               sh_carry = ror_dbl[31];
            end
         end
      endcase
   end
`else
   // no shifter: Rm passes through and the shift fields are ignored
   always_comb begin
      sh_out   = rm_val;
      sh_carry = nzcv[1];
   end
`endif

   assign dp_src2 = i_bit ? imm_rot : sh_out;

   // decode: ALU operation and operand B for data-processing vs memory
   always_comb begin
      alu_op   = ALU_ADD;
      src_b    = dp_src2;
      dp_valid = 1'b0;
      logical  = 1'b0;
      is_cmp   = 1'b0;
      if (op == 2'b01) begin
         src_b  = {20'd0, Instr[11:0]};
         alu_op = Instr[23] ? ALU_ADD : ALU_SUB;
      end else begin
         case (cmd)
            4'b0000: begin alu_op = ALU_AND; dp_valid = 1'b1; logical = 1'b1; end
            4'b0010: begin alu_op = ALU_SUB; dp_valid = 1'b1; end
            4'b0100: begin alu_op = ALU_ADD; dp_valid = 1'b1; end
            4'b1100: begin alu_op = ALU_ORR; dp_valid = 1'b1; logical = 1'b1; end
            4'b1010: begin alu_op = ALU_SUB; dp_valid = 1'b1; is_cmp = 1'b1; end
            default: begin alu_op = ALU_ADD; end
         endcase
      end
   end

   // ALU: subtraction is A + ~B + 1, so carry-out is NOT borrow
   always_comb begin
      b_eff = (alu_op == ALU_SUB) ? ~src_b : src_b;
      sum   = {1'b0, rn_val} + {1'b0, b_eff} + {32'd0, (alu_op == ALU_SUB)};
      case (alu_op)
         ALU_AND: alu_result = rn_val & src_b;
         ALU_ORR: alu_result = rn_val | src_b;
         default: alu_result = sum[31:0];
      endcase
      add_c = sum[32];
      add_v = (rn_val[31] == b_eff[31]) && (sum[31] != rn_val[31]);
   end

   // control, chipset region decode and load data selection
   always_comb begin
      is_ldr     = (op == 2'b01) & Instr[20];
      is_str     = (op == 2'b01) & ~Instr[20];
      is_b       = (op == 2'b10) & ~Instr[24];
      reg_write  = cond_ok & (((op == 2'b00) & dp_valid & ~is_cmp) | is_ldr);
      flag_write = cond_ok & (op == 2'b00) & dp_valid & (s_bit | is_cmp);
      ram_sel    = ~alu_result[10];
      read_data  = ram_sel ? RAMData : Msj;
      result_wb  = is_ldr ? read_data : alu_result;
      MemWrite   = rst & cond_ok & is_str;
      RAMEnable  = MemWrite & ram_sel;
      Addr       = alu_result;
      WriteData  = rd_val;
   end

   // next flags: logical ops keep V and take C from the shifter (register Src2)
   always_comb begin
      if (logical)
         nzcv_next = {alu_result[31], (alu_result == '0), (i_bit ? nzcv[1] : sh_carry), nzcv[0]};
      else
         nzcv_next = {alu_result[31], (alu_result == '0), add_c, add_v};
   end

   // next PC: taken branch, write to R15, or sequential (wraps mod 2^32)
   always_comb begin
      pc_next = pc_plus4;
      if (cond_ok & is_b)
         pc_next = pc_plus8 + {{6{Instr[23]}}, Instr[23:0], 2'b00};
      else if (reg_write & (rd == 4'd15))
         pc_next = result_wb;
   end

   // PC and flag state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         PC   <= '0;
         nzcv <= '0;
      end else begin
         PC <= pc_next;
         if (flag_write)
            nzcv <= nzcv_next;
      end
   end

   // general register file R0-R14
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 15; i++)
            regs[i] <= '0;
      end else if (reg_write && (rd != 4'd15)) begin
         regs[rd] <= result_wb;
      end
   end

endmodule

// File: tb/tb_cpu_subsystem.sv
// Bench for cpu_subsystem: instruction stream driven directly per cycle from a
// vector table; expected outputs queued on drive and compared at the falling edge.
module tb_cpu_subsystem;

   logic        clk;
   logic        rst;
   logic [31:0] Instr;
   logic [31:0] RAMData;
   logic [31:0] Msj;
   logic [31:0] PC;
   logic [31:0] WriteData;
   logic [31:0] Addr;
   logic        MemWrite;
   logic        RAMEnable;

   int checks;
   int errors;

`ifdef CPU_SHIFTER_EN
   localparam logic [31:0] R7_EXP = 32'h50;
`else
   localparam logic [31:0] R7_EXP = 32'h5;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] ram;
      logic [31:0] msj;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mw;
      logic        re;
      logic        ca;
      logic        cw;
   } vec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mw;
      logic        re;
      logic        ca;
      logic        cw;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];

   cpu_subsystem dut (
      .clk       (clk),
      .rst       (rst),
      .Instr     (Instr),
      .RAMData   (RAMData),
      .Msj       (Msj),
      .PC        (PC),
      .WriteData (WriteData),
      .Addr      (Addr),
      .MemWrite  (MemWrite),
      .RAMEnable (RAMEnable)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [31:0] instr, input logic [31:0] ram, input logic [31:0] msj,
                          input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic mw, input logic re, input logic ca, input logic cw);
      vec_t v;
      v.instr = instr; v.ram = ram; v.msj = msj; v.pc = pc; v.addr = addr;
      v.wdata = wdata; v.mw = mw; v.re = re; v.ca = ca; v.cw = cw;
      tbl.push_back(v);
   endtask

   // driver: apply one vector and queue its expected outputs
   task automatic drive_vec(input vec_t v);
      exp_t e;
      Instr   = v.instr;
      RAMData = v.ram;
      Msj     = v.msj;
      e.pc = v.pc; e.addr = v.addr; e.wdata = v.wdata;
      e.mw = v.mw; e.re = v.re; e.ca = v.ca; e.cw = v.cw;
      exp_q.push_back(e);
   endtask

   // scoreboard: pop one expectation and compare against current outputs
   task automatic check_out(input int idx);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_empty[%0d]: got empty queue expected entry", idx);
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("pc[%0d]", idx), PC, e.pc);
         if (e.ca) chk($sformatf("addr[%0d]", idx), Addr, e.addr);
         if (e.cw) chk($sformatf("wdata[%0d]", idx), WriteData, e.wdata);
         chk($sformatf("memwrite[%0d]", idx), {31'd0, MemWrite}, {31'd0, e.mw});
         chk($sformatf("ramenable[%0d]", idx), {31'd0, RAMEnable}, {31'd0, e.re});
      end
   endtask

   task automatic step(input vec_t v, input int idx);
      drive_vec(v);
      @(negedge clk);
      check_out(idx);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      Instr   = 32'hE5802010;
      RAMData = '0;
      Msj     = '0;

      //        instr         ram           msj           pc            addr          wdata         mw re ca cw
      add_vec(32'hE2801005, 32'h0,        32'h0,        32'h00000000, 32'h00000005, 32'h0,        0, 0, 1, 0); // ADD R1,R0,#5
      add_vec(32'hE28120FF, 32'h0,        32'h0,        32'h00000004, 32'h00000104, 32'h0,        0, 0, 1, 0); // ADD R2,R1,#FF
      add_vec(32'hE5802010, 32'h0,        32'h0,        32'h00000008, 32'h00000010, 32'h00000104, 1, 1, 1, 1); // STR R2,[R0,#10]
      add_vec(32'hE5903010, 32'h00000104, 32'hDEADBEEF, 32'h0000000C, 32'h00000010, 32'h0,        0, 0, 1, 0); // LDR R3,[R0,#10]
      add_vec(32'hE5803020, 32'h0,        32'h0,        32'h00000010, 32'h00000020, 32'h00000104, 1, 1, 1, 1); // STR R3,[R0,#20]
      add_vec(32'hE2805B01, 32'h0,        32'h0,        32'h00000014, 32'h00000400, 32'h0,        0, 0, 1, 0); // ADD R5,R0,#400
      add_vec(32'hE5954000, 32'h11111111, 32'hCAFEF00D, 32'h00000018, 32'h00000400, 32'h0,        0, 0, 1, 0); // LDR R4,[R5]
      add_vec(32'hE5854004, 32'h0,        32'h0,        32'h0000001C, 32'h00000404, 32'hCAFEF00D, 1, 0, 1, 1); // STR R4,[R5,#4]
      add_vec(32'hE515C004, 32'h0BADF00D, 32'h22222222, 32'h00000020, 32'h000003FC, 32'h0,        0, 0, 1, 0); // LDR R12,[R5,#-4]
      add_vec(32'hE580C000, 32'h0,        32'h0,        32'h00000024, 32'h00000000, 32'h0BADF00D, 1, 1, 1, 1); // STR R12,[R0]
      add_vec(32'hE181A002, 32'h0,        32'h0,        32'h00000028, 32'h00000105, 32'h0,        0, 0, 1, 0); // ORR R10,R1,R2
      add_vec(32'hE202B0FF, 32'h0,        32'h0,        32'h0000002C, 32'h00000004, 32'h0,        0, 0, 1, 0); // AND R11,R2,#FF
      add_vec(32'hE0807201, 32'h0,        32'h0,        32'h00000030, R7_EXP,       32'h0,        0, 0, 1, 0); // ADD R7,R0,R1,LSL#4
      add_vec(32'hE28F9000, 32'h0,        32'h0,        32'h00000034, 32'h0000003C, 32'h0,        0, 0, 1, 0); // ADD R9,PC,#0
      add_vec(32'hE2806003, 32'h0,        32'h0,        32'h00000038, 32'h00000003, 32'h0,        0, 0, 1, 0); // ADD R6,R0,#3
      add_vec(32'hE2566001, 32'h0,        32'h0,        32'h0000003C, 32'h00000002, 32'h0,        0, 0, 1, 0); // SUBS R6,R6,#1
      add_vec(32'h1AFFFFFD, 32'h0,        32'h0,        32'h00000040, 32'h0,        32'h0,        0, 0, 0, 0); // BNE loop (taken)
      add_vec(32'hE2566001, 32'h0,        32'h0,        32'h0000003C, 32'h00000001, 32'h0,        0, 0, 1, 0);
      add_vec(32'h1AFFFFFD, 32'h0,        32'h0,        32'h00000040, 32'h0,        32'h0,        0, 0, 0, 0); // taken
      add_vec(32'hE2566001, 32'h0,        32'h0,        32'h0000003C, 32'h00000000, 32'h0,        0, 0, 1, 0);
      add_vec(32'h1AFFFFFD, 32'h0,        32'h0,        32'h00000040, 32'h0,        32'h0,        0, 0, 0, 0); // not taken
      add_vec(32'h0A000001, 32'h0,        32'h0,        32'h00000044, 32'h0,        32'h0,        0, 0, 0, 0); // BEQ +1 (Z=1)
      add_vec(32'hE3500000, 32'h0,        32'h0,        32'h00000050, 32'h00000000, 32'h0,        0, 0, 1, 0); // CMP R0,#0
      add_vec(32'h35802030, 32'h0,        32'h0,        32'h00000054, 32'h00000030, 32'h0,        0, 0, 1, 0); // STRCC (C=1, skip)
      add_vec(32'h25802030, 32'h0,        32'h0,        32'h00000058, 32'h00000030, 32'h00000104, 1, 1, 1, 1); // STRCS
      add_vec(32'h05809034, 32'h0,        32'h0,        32'h0000005C, 32'h00000034, 32'h0000003C, 1, 1, 1, 1); // STREQ R9
      add_vec(32'hE5807038, 32'h0,        32'h0,        32'h00000060, 32'h00000038, R7_EXP,       1, 1, 1, 1); // STR R7
      add_vec(32'hE280F080, 32'h0,        32'h0,        32'h00000064, 32'h00000080, 32'h0,        0, 0, 1, 0); // ADD PC,R0,#80
      add_vec(32'hE580A000, 32'h0,        32'h0,        32'h00000080, 32'h00000000, 32'h00000105, 1, 1, 1, 1); // STR R10
      add_vec(32'hE580B000, 32'h0,        32'h0,        32'h00000084, 32'h00000000, 32'h00000004, 1, 1, 1, 1); // STR R11
      add_vec(32'hEB000010, 32'h0,        32'h0,        32'h00000088, 32'h0,        32'h0,        0, 0, 0, 0); // BL = no-op
      add_vec(32'hE250D001, 32'h0,        32'h0,        32'h0000008C, 32'hFFFFFFFF, 32'h0,        0, 0, 1, 0); // SUBS R13,R0,#1
      add_vec(32'h4580D000, 32'h0,        32'h0,        32'h00000090, 32'h00000000, 32'hFFFFFFFF, 1, 1, 1, 1); // STRMI R13
      add_vec(32'h2580D000, 32'h0,        32'h0,        32'h00000094, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1, 1); // STRCS (C=0, skip)
      add_vec(32'hEAFFFFD8, 32'h0,        32'h0,        32'h00000098, 32'h0,        32'h0,        0, 0, 0, 0); // B back to 0
      add_vec(32'hE590F000, 32'hFFFFFFFC, 32'h0,        32'h00000000, 32'h00000000, 32'h0,        0, 0, 1, 0); // LDR PC,[R0]
      add_vec(32'hEB000000, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h0,        32'h0,        0, 0, 0, 0); // no-op, PC wraps
      add_vec(32'hE5801000, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 32'h00000005, 1, 1, 1, 1); // STR R1

      // reset: hold low with a store presented; outputs must stay quiet
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc", PC, 32'h0);
      chk("rst_memwrite", {31'd0, MemWrite}, 32'h0);
      chk("rst_ramenable", {31'd0, RAMEnable}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i], i);

      // asynchronous reset mid-cycle clears PC immediately and blocks the store
      Instr = 32'hE5801000;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_pc", PC, 32'h0);
      chk("async_rst_memwrite", {31'd0, MemWrite}, 32'h0);
      chk("async_rst_ramenable", {31'd0, RAMEnable}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      // registers and flags cleared: R1 reads 0, BEQ not taken
      v = '{32'hE5801000, 32'h0, 32'h0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1};
      step(v, 100);
      v = '{32'h0A000001, 32'h0, 32'h0, 32'h00000004, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      step(v, 101);
      v = '{32'hE5801000, 32'h0, 32'h0, 32'h00000008, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1};
      step(v, 102);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
